remote_update_wconv_fifo: RTL and testbench
===========================================

// Module: remote_update_wconv_fifo
// PURPOSE
//  Synchronous width-converting FIFO for the remote-update write path. It takes wide
//  bitstream words and returns them as narrow words, with the write:read width ratio
//  set by a parameter. It reports occupancy on both sides, has programmable almost
//  flags and flags overflow/underflow errors. Sits between the host packet unpacker and
//  the flash-programming byte engine, replacing the fixed 32->8 vendor FIFO.
// PARAMETERS
//  WR_DATA_WIDTH    32   write word width; must equal RATIO*RD_DATA_WIDTH
//  RD_DATA_WIDTH    8    read word width
//  RATIO            4    write/read width ratio; power of two, 1..16
//  WR_DEPTH_WIDTH   9    log2 of depth in write words (512)
//  ALMOST_FULL_NUM  500  almost_full threshold, in write words
//  ALMOST_EMPTY_NUM 4    almost_empty threshold, in read words
//  MSB_FIRST        1    1: read the write word's MSB slice first; 0: read the LSB slice first
//  Derived: RD_DEPTH_WIDTH = WR_DEPTH_WIDTH + log2(RATIO); DEPTH = 2**RD_DEPTH_WIDTH read words
// PORTS
//  clk            in   1                    clock clk; all logic on rising edge
//  tb_rst         in   1                    reset tb_rst, asynchronous, active-high
//  wr_data        in   WR_DATA_WIDTH        write word
//  wr_en          in   1                    write request
//  wr_full        out  1                    fewer than RATIO read slots free
//  almost_full    out  1                    wr_water_level >= ALMOST_FULL_NUM
//  wr_water_level out  WR_DEPTH_WIDTH+1     stored data in write words, rounded up
//  wr_overflow    out  1                    1-cycle pulse: wr_en while wr_full
//  rd_data        out  RD_DATA_WIDTH        read word
//  rd_en          in   1                    read request
//  rd_empty       out  1                    level == 0
//  almost_empty   out  1                    rd_water_level <= ALMOST_EMPTY_NUM
//  rd_water_level out  RD_DEPTH_WIDTH+1     stored data in read words
//  rd_underflow   out  1                    1-cycle pulse: rd_en while rd_empty
// BEHAVIOUR
//  - Storage: DEPTH x RD_DATA_WIDTH memory.
//  - Pointers: wr_ptr has RD_DEPTH_WIDTH+1 bits and steps by RATIO; rd_ptr has
//    RD_DEPTH_WIDTH+1 bits and steps by 1. Both wrap naturally (modulo 2**(RD_DEPTH_WIDTH+1)).
//  - Level: registered counter in read words.
//    - Accepted write alone: +RATIO.  Accepted read alone: -1.  Both in one cycle: +RATIO-1.
//  - Write is accepted when wr_en && !wr_full.
//    - All RATIO slices are stored in one cycle.
//    - Slice k is read k-th: with MSB_FIRST=1, slice 0 = wr_data[W-1 -: RD_DATA_WIDTH].
//  - Read is accepted when rd_en && !rd_empty.
//    - rd_data is registered and valid 1 cycle after the accepted rd_en.
//    - rd_data holds its last value otherwise.
//  - Rejected requests change no state.
//    - wr_overflow / rd_underflow assert for exactly the cycle after the rejected request.
//  - Flags and levels come combinationally from the level register, so they reflect an
//    operation from the cycle after it.
//    - wr_full uses the post-update level.
//    - A read and write in the same cycle when level == DEPTH-RATIO+1: the write is
//      rejected (wr_full is already high), and the read proceeds.
//  - wr_water_level = ceil(level / RATIO).
//  - Reset (asynchronous, any time, including mid-burst):
//    - pointers = 0, level = 0, rd_data = 0.
//    - wr_full = 0, almost_full = 0, rd_empty = 1, almost_empty = 1.
//    - both error pulses = 0; water levels = 0.
//  - Reset releases synchronously to clk inside the block, using a 2-flop release synchroniser.
// CONFIGURATION
//  - Macro RU_WCONV_FIFO_OUTPUT_REG_EN:
//    - Defined: adds an output register after the read register, so read latency is
//      2 cycles. The register stage updates only on the delayed accepted read. Reset value 0.
//    - Not defined: read latency is 1 cycle, and there is no extra register stage.
//  - Flags, levels and error pulses are identical in both builds.
// TESTING
//  1. Write 512 words counting down from 0xFFFFFFFF, then read 2048 reads ->
//     bytes FF,FF,FF,FF,FF,FF,FF,FE,... Then rd_empty=1 and no mismatches.
//  2. Fill to 512 words -> wr_full=1, almost_full=1 from 500 words on, wr_water_level=512.
//     A 513th write -> wr_overflow pulses once, and the contents are unchanged.
//  3. Issue rd_en on an empty FIFO -> rd_underflow pulses once, and rd_water_level stays 0.
//  4. Hold level=40 and do a simultaneous write+read for 10 cycles -> rd_water_level=70,
//     and the data order is preserved.
//  5. Set MSB_FIRST=0 and write 0x11223344 -> the reads return 44,33,22,11.
//     Check latency 1 without the macro and 2 with RU_WCONV_FIFO_OUTPUT_REG_EN.
//  6. Assert tb_rst mid-burst at level 300 -> all outputs reach their reset values
//     immediately. The next write/read round-trip is correct.

Source files
------------

// File: rtl/remote_update_wconv_fifo.sv
// Width-converting FIFO for the remote-update write path: wide words in, narrow words out.
// Define RU_WCONV_FIFO_OUTPUT_REG_EN for an extra output register (read latency 2).
module remote_update_wconv_fifo #(
  parameter int WR_DATA_WIDTH    = 32,
  parameter int RD_DATA_WIDTH    = 8,
  parameter int RATIO            = 4,
  parameter int WR_DEPTH_WIDTH   = 9,
  parameter int ALMOST_FULL_NUM  = 500,
  parameter int ALMOST_EMPTY_NUM = 4,
  parameter bit MSB_FIRST        = 1'b1
) (
  input  logic                      clk,
  input  logic                      tb_rst,
  input  logic [WR_DATA_WIDTH-1:0]  wr_data,
  input  logic                      wr_en,
  output logic                      wr_full,
  output logic                      almost_full,
  output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  output logic                      wr_overflow,
  output logic [RD_DATA_WIDTH-1:0]  rd_data,
  input  logic                      rd_en,
  output logic                      rd_empty,
  output logic                      almost_empty,
  output logic [WR_DEPTH_WIDTH+$clog2(RATIO):0] rd_water_level,
  output logic                      rd_underflow
);

  localparam int RL    = $clog2(RATIO);
  localparam int RDW   = WR_DEPTH_WIDTH + RL;
  localparam int WDW   = WR_DEPTH_WIDTH;
  localparam int DEPTH = 2 ** RDW;
  localparam int RD    = RD_DATA_WIDTH;

  localparam logic [RDW:0] STEP    = (RDW+1)'(RATIO);
  localparam logic [RDW:0] FULL_TH = (RDW+1)'(DEPTH - RATIO);
  localparam logic [RDW:0] AE_TH   = (RDW+1)'(ALMOST_EMPTY_NUM);
  localparam logic [WDW:0] AF_TH   = (WDW+1)'(ALMOST_FULL_NUM);

  logic [1:0]     r_rst_sync;
  logic           w_rst;
  logic [RDW:0]   r_wr_ptr;
  logic [RDW:0]   r_rd_ptr;
  logic [RDW:0]   r_level;
  logic [RDW:0]   w_ceil;
  logic [RDW-1:0] w_waddr;
  logic [RDW-1:0] w_raddr;
  logic           w_wr_acc;
  logic           w_rd_acc;
  logic           r_ovf;
  logic           r_udf;
  logic [RD-1:0]  r_rd_data;
  logic [RD-1:0]  r_mem [DEPTH];
  logic [RD-1:0]  w_slice [RATIO];

  // assert asynchronously, release two clocks later
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) r_rst_sync <= 2'b11;
    else        r_rst_sync <= {r_rst_sync[0], 1'b0};
  end
  assign w_rst = r_rst_sync[1];

  assign wr_full        = r_level > FULL_TH;
  assign rd_empty       = r_level == '0;
  assign rd_water_level = r_level;
  assign w_ceil         = r_level + (RDW+1)'(RATIO - 1);
  assign wr_water_level = (WDW+1)'(w_ceil >> RL);
  assign almost_full    = wr_water_level >= AF_TH;
  assign almost_empty   = r_level <= AE_TH;
  assign wr_overflow    = r_ovf;
  assign rd_underflow   = r_udf;

  assign w_wr_acc = wr_en && !wr_full;
  assign w_rd_acc = rd_en && !rd_empty;
  assign w_waddr  = RDW'(r_wr_ptr);
  assign w_raddr  = RDW'(r_rd_ptr);

  // slice k is the k-th narrow word read out
  for (genvar g = 0; g < RATIO; g++) begin : g_slice
    if (MSB_FIRST) begin : g_msb
      assign w_slice[g] = wr_data[WR_DATA_WIDTH-1-g*RD -: RD];
    end else begin : g_lsb
      assign w_slice[g] = wr_data[g*RD +: RD];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      for (int k = 0; k < RATIO; k++)
        r_mem[w_waddr + RDW'(k)] <= w_slice[k];
    end
  end

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_ovf <= wr_en && wr_full;
      r_udf <= rd_en && rd_empty;
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + STEP;
      if (w_rd_acc) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_data <= r_mem[w_raddr];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + STEP;
        2'b01:   r_level <= r_level - 1'b1;
        2'b11:   r_level <= r_level + STEP - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef RU_WCONV_FIFO_OUTPUT_REG_EN
  logic          r_rd_vld;
  logic [RD-1:0] r_rd_out;

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_rd_vld <= 1'b0;
      r_rd_out <= '0;
    end else begin
      r_rd_vld <= w_rd_acc;
      if (r_rd_vld) r_rd_out <= r_rd_data;
    end
  end
  assign rd_data = r_rd_out;
`else
  assign rd_data = r_rd_data;
`endif

endmodule

// File: tb/tb_remote_update_wconv_fifo.sv
// Directed bench for remote_update_wconv_fifo: a byte queue holds
// the expected read stream, a second instance covers LSB-first order.
module tb_remote_update_wconv_fifo;

`ifdef RU_WCONV_FIFO_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        tb_rst = 1'b1;
  logic [31:0] wr_data = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_full, almost_full, wr_overflow;
  logic        rd_empty, almost_empty, rd_underflow;
  logic [9:0]  wr_water_level;
  logic [11:0] rd_water_level;
  logic [7:0]  rd_data;

  logic [31:0] l_wr_data = '0;
  logic        l_wr_en = 1'b0;
  logic        l_rd_en = 1'b0;
  logic        l_wr_full, l_almost_full, l_wr_overflow;
  logic        l_rd_empty, l_almost_empty, l_rd_underflow;
  logic [4:0]  l_wr_water_level;
  logic [6:0]  l_rd_water_level;
  logic [7:0]  l_rd_data;

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  q [$];
  logic [7:0]  last_exp;
  logic [7:0]  e   [10];
  logic [7:0]  obs [16];
  logic [7:0]  lb  [4];

  always #5 clk = ~clk;

  remote_update_wconv_fifo u_dut (
    .clk(clk), .tb_rst(tb_rst),
    .wr_data(wr_data), .wr_en(wr_en),
    .wr_full(wr_full), .almost_full(almost_full),
    .wr_water_level(wr_water_level), .wr_overflow(wr_overflow),
    .rd_data(rd_data), .rd_en(rd_en),
    .rd_empty(rd_empty), .almost_empty(almost_empty),
    .rd_water_level(rd_water_level), .rd_underflow(rd_underflow)
  );

  remote_update_wconv_fifo #(
    .WR_DEPTH_WIDTH(4), .ALMOST_FULL_NUM(14), .MSB_FIRST(1'b0)
  ) u_lsb (
    .clk(clk), .tb_rst(tb_rst),
    .wr_data(l_wr_data), .wr_en(l_wr_en),
    .wr_full(l_wr_full), .almost_full(l_almost_full),
    .wr_water_level(l_wr_water_level), .wr_overflow(l_wr_overflow),
    .rd_data(l_rd_data), .rd_en(l_rd_en),
    .rd_empty(l_rd_empty), .almost_empty(l_almost_empty),
    .rd_water_level(l_rd_water_level), .rd_underflow(l_rd_underflow)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int j = 0; j < 4; j++) q.push_back(w[31-8*j -: 8]);
  endtask

  // called at a negedge, returns at the next negedge
  task automatic wr_word(input logic [31:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    if (q.size() <= 2044) push_word(w);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    last_exp = q.pop_front();
    check(tag, rd_data, last_exp);
  endtask

  task automatic rst_cycle();
    tb_rst = 1'b1;
    repeat (3) @(negedge clk);
    tb_rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int idx;
    repeat (3) @(negedge clk);
    check("rst_empty", rd_empty, 1);
    check("rst_aempty", almost_empty, 1);
    check("rst_full", wr_full, 0);
    check("rst_afull", almost_full, 0);
    check("rst_rlvl", rd_water_level, 0);
    check("rst_wlvl", wr_water_level, 0);
    check("rst_rdata", rd_data, 0);
    tb_rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: countdown words round trip
    for (int i = 0; i < 512; i++) wr_word(32'hFFFF_FFFF - i);
    check("t1_full", wr_full, 1);
    check("t1_rlvl", rd_water_level, 2048);
    for (int i = 0; i < 2048; i++) rd_chk("t1_data");
    check("t1_empty", rd_empty, 1);

    // 2: fill thresholds and overflow
    for (int i = 0; i < 512; i++) begin
      wr_word(32'hA500_0000 + i);
      if (i == 3)   check("t2_aempty_lo", almost_empty, 0);
      if (i == 498) check("t2_afull_499", almost_full, 0);
      if (i == 499) check("t2_afull_500", almost_full, 1);
      if (i == 510) check("t2_full_511", wr_full, 0);
    end
    check("t2_full", wr_full, 1);
    check("t2_afull", almost_full, 1);
    check("t2_wlvl", wr_water_level, 512);
    wr_word(32'hDEAD_BEEF);
    check("t2_ovf_pulse", wr_overflow, 1);
    @(negedge clk);
    check("t2_ovf_clear", wr_overflow, 0);
    check("t2_rlvl", rd_water_level, 2048);
    for (int i = 0; i < 2048; i++) rd_chk("t2_data");
    check("t2_empty", rd_empty, 1);

    // 3: underflow
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check("t3_udf_pulse", rd_underflow, 1);
    check("t3_rlvl", rd_water_level, 0);
    @(negedge clk);
    check("t3_udf_clear", rd_underflow, 0);
    check("t3_rdata_hold", rd_data, last_exp);

    // 4: simultaneous write+read at level 40
    for (int i = 0; i < 10; i++) wr_word(32'hC0DE_0000 + i);
    check("t4_lvl40", rd_water_level, 40);
    for (int c = 0; c < 10 + LAT - 1; c++) begin
      wr_en   = (c < 10);
      rd_en   = (c < 10);
      wr_data = 32'hC0DE_0000 + 10 + c;
      if (c < 10) begin
        push_word(wr_data);
        e[c] = q.pop_front();
      end
      @(negedge clk);
      obs[c] = rd_data;
      if (c == 9) check("t4_lvl70", rd_water_level, 70);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    for (int j = 0; j < 10; j++) check("t4_stream", obs[j+LAT-1], e[j]);
    for (int i = 0; i < 70; i++) rd_chk("t4_drain");
    check("t4_empty", rd_empty, 1);

    // 5: LSB-first order and read latency
    lb[0] = 8'h44; lb[1] = 8'h33; lb[2] = 8'h22; lb[3] = 8'h11;
    check("t5_rdata_rst", l_rd_data, 0);
    l_wr_en   = 1'b1;
    l_wr_data = 32'h1122_3344;
    @(negedge clk);
    l_wr_en = 1'b0;
    check("t5_lvl", l_rd_water_level, 4);
    for (int c = 0; c < 4 + LAT; c++) begin
      l_rd_en = (c < 4);
      @(negedge clk);
      obs[c] = l_rd_data;
    end
    l_rd_en = 1'b0;
    for (int c = 0; c < 4 + LAT; c++) begin
      idx = c - (LAT - 1);
      if (idx > 3) idx = 3;
      check("t5_lsb", obs[c], (idx < 0) ? 8'h00 : lb[idx]);
    end
    check("t5_empty", l_rd_empty, 1);

    // 6: reset mid-burst at level 300
    for (int i = 0; i < 75; i++) wr_word(32'h1357_0000 + i);
    check("t6_lvl300", rd_water_level, 300);
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 32'h2468_ACE0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 tb_rst = 1'b1;
    #1;
    check("t6_rlvl", rd_water_level, 0);
    check("t6_wlvl", wr_water_level, 0);
    check("t6_empty", rd_empty, 1);
    check("t6_aempty", almost_empty, 1);
    check("t6_full", wr_full, 0);
    check("t6_afull", almost_full, 0);
    check("t6_rdata", rd_data, 0);
    check("t6_ovf", wr_overflow, 0);
    check("t6_udf", rd_underflow, 0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    q.delete();
    @(negedge clk);
    rst_cycle();
    wr_word(32'h5A6B_7C8D);
    check("t6_post_lvl", rd_water_level, 4);
    for (int i = 0; i < 4; i++) rd_chk("t6_post_data");
    check("t6_post_empty", rd_empty, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
